// File: rtl/simd_issue_q.sv
// simd_issue_q: command queue plus result register around the combinational
// SIMD add/sub/mul array. Commands are pushed with valid/ready. The queue
// head feeds the array directly. The array result is registered and offered
// downstream with valid/ready.
// Optional build macro: SIMD_ISSUE_ILLEGAL_CHK_EN. When it is defined, a
// push with opcode 2'b11 is accepted but dropped, and the sticky o_illegal
// flag is set.

module simd_issue_q #(
   parameter int width         = 4,
   parameter int operand_width = 32,
   parameter int depth         = 4
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_valid,
   output logic                             o_ready,
   input  logic [1:0]                       i_opcode,
   input  logic [width*operand_width-1:0]   i_in1,
   input  logic [width*operand_width-1:0]   i_in2,
   output logic [1:0]                       o_opcode,
   output logic [width*operand_width-1:0]   o_in1,
   output logic [width*operand_width-1:0]   o_in2,
   input  logic [width*operand_width-1:0]   i_res,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [width*operand_width-1:0]   o_res,
   output logic [1:0]                       o_res_op,
   output logic [$clog2(depth):0]           o_count
`ifdef SIMD_ISSUE_ILLEGAL_CHK_EN
   ,
   output logic                             o_illegal
`endif
);

   localparam int dw = width * operand_width;
   localparam int aw = $clog2(depth);
   localparam int cw = aw + 1;
   localparam logic [cw-1:0] full_count = cw'(depth);

   // Command storage. It has no reset because the pointers and the count
   // decide which entries are live.
   logic [1:0]    mem_op  [depth];
   logic [dw-1:0] mem_in1 [depth];
   logic [dw-1:0] mem_in2 [depth];

   logic [aw-1:0] wr_ptr;
   logic [aw-1:0] rd_ptr;
   logic [cw-1:0] count;

   logic push;
   logic enq;
   logic cap;
   logic empty;

   assign empty   = (count == '0);
   assign o_ready = (count != full_count);
   assign o_count = count;

   // Acceptance looks only at occupancy. A full queue refuses a command
   // even when a pop happens in the same cycle.
   assign push = i_valid && o_ready;
   assign cap  = !empty && (!o_valid || i_ready);

`ifdef SIMD_ISSUE_ILLEGAL_CHK_EN
   logic drop;
   assign drop = push && (i_opcode == 2'b11);
   assign enq  = push && !drop;
`else
   assign enq  = push;
`endif

   // Write the accepted command into the tail slot
   always_ff @(posedge i_clk) begin
      if (enq) begin
         mem_op[wr_ptr]  <= i_opcode;
         mem_in1[wr_ptr] <= i_in1;
         mem_in2[wr_ptr] <= i_in2;
      end
   end

   // Pointer and occupancy bookkeeping. Pointers wrap because depth is a
   // power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + aw'(1);
         if (cap) rd_ptr <= rd_ptr + aw'(1);
         count <= count + cw'(enq) - cw'(cap);
      end
   end

   // The head entry drives the array. Outputs are zero while the queue is empty.
   always_comb begin
      o_opcode = '0;
      o_in1    = '0;
      o_in2    = '0;
      if (!empty) begin
         o_opcode = mem_op[rd_ptr];
         o_in1    = mem_in1[rd_ptr];
         o_in2    = mem_in2[rd_ptr];
      end
   end

   // Result register. It captures the array output when the slot is free
   // or is being consumed, and holds its value under backpressure.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid  <= 1'b0;
         o_res    <= '0;
         o_res_op <= '0;
      end else if (cap) begin
         o_valid  <= 1'b1;
         o_res    <= i_res;
         o_res_op <= o_opcode;
      end else if (o_valid && i_ready) begin
         o_valid  <= 1'b0;
      end
   end

`ifdef SIMD_ISSUE_ILLEGAL_CHK_EN
   // Sticky flag for a dropped illegal command. Only reset clears it.
   always_ff @(posedge i_clk) begin
      if (i_rst)     o_illegal <= 1'b0;
      else if (drop) o_illegal <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_simd_issue_q.sv
// tb_simd_issue_q: directed testbench for simd_issue_q. A behavioural model
// of the SIMD array closes the loop from the head outputs to i_res.
// Build with SIMD_ISSUE_ILLEGAL_CHK_EN to exercise the illegal-drop path.

module tb_simd_issue_q;

   localparam int dw = 128;

   logic          clk;
   logic          rst;
   logic          valid;
   logic          rdy_up;
   logic [1:0]    opcode;
   logic [dw-1:0] in1;
   logic [dw-1:0] in2;
   logic [1:0]    head_op;
   logic [dw-1:0] head_in1;
   logic [dw-1:0] head_in2;
   logic [dw-1:0] arr_res;
   logic          res_valid;
   logic          ds_ready;
   logic [dw-1:0] res;
   logic [1:0]    res_op;
   logic [2:0]    count;
`ifdef SIMD_ISSUE_ILLEGAL_CHK_EN
   logic          illegal;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   simd_issue_q #(.width(4), .operand_width(32), .depth(4)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_valid  (valid),
      .o_ready  (rdy_up),
      .i_opcode (opcode),
      .i_in1    (in1),
      .i_in2    (in2),
      .o_opcode (head_op),
      .o_in1    (head_in1),
      .o_in2    (head_in2),
      .i_res    (arr_res),
      .o_valid  (res_valid),
      .i_ready  (ds_ready),
      .o_res    (res),
      .o_res_op (res_op),
      .o_count  (count)
`ifdef SIMD_ISSUE_ILLEGAL_CHK_EN
      ,
      .o_illegal(illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Array model. The array computes sub for opcode 11.
   function automatic logic [31:0] lane_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00:   return a + b;
         2'b10:   return a * b;
         default: return a - b;
      endcase
   endfunction

   always_comb begin
      arr_res = '0;
      for (int k = 0; k < 4; k++)
         arr_res[k*32 +: 32] = lane_op(head_op, head_in1[k*32 +: 32], head_in2[k*32 +: 32]);
   end

   function automatic logic [dw-1:0] pack(input logic [31:0] l3, input logic [31:0] l2,
                                          input logic [31:0] l1, input logic [31:0] l0);
      return {l3, l2, l1, l0};
   endfunction

   task automatic chk(input string tag, input logic [dw-1:0] got, input logic [dw-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Push one command into an idle, empty stage, then check latency, value and drain
   task automatic run_one(input string tag, input logic [1:0] op, input logic [dw-1:0] a,
                          input logic [dw-1:0] b, input logic [dw-1:0] exp);
      valid = 1'b1; opcode = op; in1 = a; in2 = b;
      tick;
      valid = 1'b0;
      chk({tag, "_cnt1"}, dw'(count), 1);
      chk({tag, "_nv1"}, dw'(res_valid), 0);
      chk({tag, "_head"}, head_in1, a);
      tick;
      chk({tag, "_v"}, dw'(res_valid), 1);
      chk({tag, "_res"}, res, exp);
      chk({tag, "_op"}, dw'(res_op), dw'(op));
      chk({tag, "_cnt0"}, dw'(count), 0);
      tick;
      chk({tag, "_drain"}, dw'(res_valid), 0);
   endtask

   function automatic logic [dw-1:0] ca(input int k);
      return {4{32'(k + 1)}};
   endfunction
   function automatic logic [dw-1:0] cb(input int k);
      return {4{32'(10 * (k + 1))}};
   endfunction
   function automatic logic [dw-1:0] ce(input int k);
      return {4{32'(11 * (k + 1))}};
   endfunction

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; valid = 1'b0; opcode = '0; in1 = '0; in2 = '0; ds_ready = 1'b1;
      tick; tick;
      rst = 1'b0;
      chk("rst_cnt", dw'(count), 0);
      chk("rst_valid", dw'(res_valid), 0);
      chk("rst_res", res, 0);
      chk("rst_resop", dw'(res_op), 0);
      chk("rst_ready", dw'(rdy_up), 1);
      chk("rst_head", head_in1, 0);

      // Basic add, sub, mul and mul truncation
      run_one("add", 2'b00, pack(4, 3, 2, 1), pack(40, 30, 20, 10), pack(44, 33, 22, 11));
      run_one("sub", 2'b01, pack(0, 0, 9, 1), pack(0, 0, 2, 3), pack(0, 0, 7, 32'hFFFF_FFFE));
      run_one("mul", 2'b10, pack(0, 0, 7, 32'hFFFF_FFFD), pack(0, 0, 6, 5), pack(0, 0, 42, 32'hFFFF_FFF1));
      run_one("mult", 2'b10, pack(0, 32'h10000, 0, 32'h10000), pack(0, 3, 0, 32'h10000), pack(0, 32'h30000, 0, 0));
`ifndef SIMD_ISSUE_ILLEGAL_CHK_EN
      run_one("op11", 2'b11, pack(0, 0, 0, 10), pack(0, 0, 0, 3), pack(0, 0, 0, 7));
`endif

      // Backpressure: five pushes against a stalled output fill the queue
      ds_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         valid = 1'b1; opcode = 2'b00; in1 = ca(k); in2 = cb(k);
         tick;
      end
      chk("full_cnt", dw'(count), 4);
      chk("full_ready", dw'(rdy_up), 0);
      chk("full_res", res, ce(0));
      // An extra stalled cycle leaves everything unchanged
      in1 = ca(9); in2 = cb(9);
      tick;
      chk("stall_cnt", dw'(count), 4);
      chk("stall_res", res, ce(0));
      // Full queue refuses a push even though this edge pops
      ds_ready = 1'b1;
      tick;
      valid = 1'b0;
      chk("fullpop_cnt", dw'(count), 3);
      chk("fullpop_res", res, ce(1));
      for (int k = 2; k < 5; k++) begin
         tick;
         chk($sformatf("order%0d", k), res, ce(k));
         chk($sformatf("order%0d_v", k), dw'(res_valid), 1);
      end
      tick;
      chk("bp_drain_v", dw'(res_valid), 0);
      chk("bp_drain_cnt", dw'(count), 0);

      // Simultaneous push and pop at count 2
      ds_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         valid = 1'b1; opcode = 2'b00; in1 = ca(k + 20); in2 = cb(k + 20);
         tick;
      end
      chk("pp_pre_cnt", dw'(count), 2);
      chk("pp_pre_res", res, ce(20));
      in1 = ca(23); in2 = cb(23); ds_ready = 1'b1;
      tick;
      valid = 1'b0;
      chk("pp_cnt", dw'(count), 2);
      chk("pp_res", res, ce(21));
      tick;
      chk("pp_res2", res, ce(22));
      tick;
      chk("pp_res3", res, ce(23));
      tick;
      chk("pp_drain", dw'(res_valid), 0);

      // Reset in the middle of operation
      ds_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         valid = 1'b1; opcode = 2'b00; in1 = ca(k + 30); in2 = cb(k + 30);
         tick;
      end
      chk("mr_pre_cnt", dw'(count), 3);
      chk("mr_pre_v", dw'(res_valid), 1);
      rst = 1'b1; ds_ready = 1'b1; in1 = ca(40); in2 = cb(40);
      tick;
      rst = 1'b0; valid = 1'b0;
      chk("mr_cnt", dw'(count), 0);
      chk("mr_v", dw'(res_valid), 0);
      chk("mr_res", res, 0);
      for (int k = 0; k < 3; k++) begin
         tick;
         chk($sformatf("mr_quiet%0d", k), dw'(res_valid), 0);
      end

`ifdef SIMD_ISSUE_ILLEGAL_CHK_EN
      // Illegal command is accepted and dropped, and the following add still flows
      chk("ill_init", dw'(illegal), 0);
      valid = 1'b1; opcode = 2'b11; in1 = pack(0, 0, 0, 1); in2 = pack(0, 0, 0, 1);
      tick;
      chk("ill_flag", dw'(illegal), 1);
      chk("ill_cnt", dw'(count), 0);
      opcode = 2'b00; in1 = pack(1, 2, 3, 4); in2 = pack(10, 20, 30, 40);
      tick;
      valid = 1'b0;
      chk("ill_cnt1", dw'(count), 1);
      tick;
      chk("ill_v", dw'(res_valid), 1);
      chk("ill_res", res, pack(11, 22, 33, 44));
      chk("ill_op", dw'(res_op), 0);
      tick;
      chk("ill_drain", dw'(res_valid), 0);
      chk("ill_sticky", dw'(illegal), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
